// File: rtl/sram_pkg.sv
// Shared data-memory region map and writer types, used by both the read-side
// extender and the store writer so both decode regions identically.
package sram_pkg;

    localparam int ADDR_W         = 11;
    localparam int SRAM_W         = 16;
    localparam int DATA_W         = 32;
    localparam int SIGNED_LIMIT   = 5;
    localparam int UNSIGNED_LIMIT = 9;

    typedef enum logic [1:0] {
        REG_SIGNED,
        REG_UNSIGNED,
        REG_WORD
    } regionT;

    typedef enum logic [1:0] {
        IDLE,
        WR_LO,
        WR_HI,
        FAULT
    } writerStateT;

endpackage

// File: rtl/sram_store_narrow.sv
// Combinational region decode plus the overflow and fault predicates for one
// store request. Also usable on its own as a reference for the region map.
module sram_store_narrow
    import sram_pkg::*;
(
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    output regionT            region,
    output logic              overflow,
    output logic              fault
);

    logic [DATA_W-SRAM_W:0]   signedTop;
    logic [DATA_W-SRAM_W-1:0] unsignedTop;

    assign signedTop   = data[DATA_W-1:SRAM_W-1];
    assign unsignedTop = data[DATA_W-1:SRAM_W];

    always_comb begin
        region = REG_WORD;
        if (addr < ADDR_W'(SIGNED_LIMIT)) begin
            region = REG_SIGNED;
        end else if (addr < ADDR_W'(UNSIGNED_LIMIT)) begin
            region = REG_UNSIGNED;
        end
    end

    // A signed halfword fits only if the discarded bits all repeat bit 15.
    always_comb begin
        overflow = 1'b0;
        case (region)
            REG_SIGNED:   overflow = !((&signedTop) || (~|signedTop));
            REG_UNSIGNED: overflow = |unsignedTop;
            default:      overflow = 1'b0;
        endcase
    end

    // The high half of a word at the top address would fall off the SRAM.
    assign fault = (region == REG_WORD) && (&addr);

endmodule

// File: rtl/sram_store_writer.sv
// Turns 32-bit MEM-stage stores into one or two 16-bit SRAM write cycles,
// narrowing by region and flagging overflow or rejected word stores.
//
// state | meaning
// IDLE  | ready for a request, no SRAM cycle
// WR_LO | writing low halfword (the only write for halfword regions)
// WR_HI | writing high halfword of a word store at addr+1
// FAULT | word store at the top address rejected, done+error, no write
module sram_store_writer
    import sram_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              store_valid,
    output logic              store_ready,
    input  logic [ADDR_W-1:0] store_addr,
    input  logic [DATA_W-1:0] store_data,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [SRAM_W-1:0] sram_wdata,
    output logic              done,
    output logic              overflow,
    output logic              error
);

    writerStateT       state;
    regionT            regionReg;
    logic [ADDR_W-1:0] addrReg;
    logic [SRAM_W-1:0] dataHiReg;

    regionT            reqRegion;
    logic              reqOverflow;
    logic              reqFault;
    logic              accept;

    sram_store_narrow uNarrow (
        .addr     (store_addr),
        .data     (store_data),
        .region   (reqRegion),
        .overflow (reqOverflow),
        .fault    (reqFault)
    );

    assign accept = store_valid && store_ready;

    // Outputs are registered alongside the state, so each one already holds
    // the value for the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            regionReg   <= REG_SIGNED;
            addrReg     <= '0;
            dataHiReg   <= '0;
            store_ready <= 1'b1;
            sram_we     <= 1'b0;
            sram_addr   <= '0;
            sram_wdata  <= '0;
            done        <= 1'b0;
            overflow    <= 1'b0;
            error       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        regionReg   <= reqRegion;
                        addrReg     <= store_addr;
                        dataHiReg   <= store_data[DATA_W-1:SRAM_W];
                        store_ready <= 1'b0;
                        if (reqFault) begin
                            state <= FAULT;
                            done  <= 1'b1;
                            error <= 1'b1;
                        end else begin
                            state      <= WR_LO;
                            sram_we    <= 1'b1;
                            sram_addr  <= store_addr;
                            sram_wdata <= store_data[SRAM_W-1:0];
                            done       <= (reqRegion != REG_WORD);
                            overflow   <= reqOverflow;
                        end
                    end
                end
                WR_LO: begin
                    if (regionReg == REG_WORD) begin
                        state      <= WR_HI;
                        sram_we    <= 1'b1;
                        sram_addr  <= addrReg + ADDR_W'(1);
                        sram_wdata <= dataHiReg;
                        done       <= 1'b1;
                        overflow   <= 1'b0;
                    end else begin
                        state       <= IDLE;
                        store_ready <= 1'b1;
                        sram_we     <= 1'b0;
                        sram_addr   <= '0;
                        sram_wdata  <= '0;
                        done        <= 1'b0;
                        overflow    <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    store_ready <= 1'b1;
                    sram_we     <= 1'b0;
                    sram_addr   <= '0;
                    sram_wdata  <= '0;
                    done        <= 1'b0;
                    overflow    <= 1'b0;
                    error       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_store_writer.sv
// Randomised and directed stores against a cycle-level expectation built from
// the region map with plain arithmetic.
module tb_sram_store_writer;

    logic        clk;
    logic        reset;
    logic        store_valid;
    logic        store_ready;
    logic [10:0] store_addr;
    logic [31:0] store_data;
    logic        sram_we;
    logic [10:0] sram_addr;
    logic [15:0] sram_wdata;
    logic        done;
    logic        overflow;
    logic        error;

    int total = 0;
    int bad   = 0;

    sram_store_writer dut (
        .clk         (clk),
        .reset       (reset),
        .store_valid (store_valid),
        .store_ready (store_ready),
        .store_addr  (store_addr),
        .store_data  (store_data),
        .sram_we     (sram_we),
        .sram_addr   (sram_addr),
        .sram_wdata  (sram_wdata),
        .done        (done),
        .overflow    (overflow),
        .error       (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic checkCycle(input string tag, input int we, input int addr, input int wdata,
                              input int dn, input int ovf, input int err);
        chk({tag, ".ready"}, 32'(store_ready), 32'd0);
        chk({tag, ".we"}, 32'(sram_we), 32'(we));
        if (we != 0) begin
            chk({tag, ".addr"}, 32'(sram_addr), 32'(addr));
            chk({tag, ".wdata"}, 32'(sram_wdata), 32'(wdata));
        end
        chk({tag, ".done"}, 32'(done), 32'(dn));
        chk({tag, ".ovf"}, 32'(overflow), 32'(ovf));
        chk({tag, ".err"}, 32'(error), 32'(err));
    endtask

    task automatic scramble();
        store_addr = 11'($urandom_range(0, 2047));
        store_data = $urandom;
    endtask

    // One request: offered in an idle cycle, then every following cycle up to
    // done is compared with what the region map says should happen.
    task automatic doStore(input string tag, input int a, input logic [31:0] d, input bit hold);
        bit  ovf;
        int  hi17;
        @(negedge clk);
        chk({tag, ".idleReady"}, 32'(store_ready), 32'd1);
        chk({tag, ".idleWe"}, 32'(sram_we), 32'd0);
        chk({tag, ".idleDone"}, 32'(done), 32'd0);
        store_valid = 1'b1;
        store_addr  = 11'(a);
        store_data  = d;
        @(posedge clk);
        #1;
        if (hold) scramble();
        else store_valid = 1'b0;

        @(negedge clk);
        if (a >= 9 && a == 2047) begin
            checkCycle({tag, ".fault"}, 0, 0, 0, 1, 0, 1);
        end else if (a >= 9) begin
            checkCycle({tag, ".lo"}, 1, a, int'(d & 32'hFFFF), 0, 0, 0);
            if (hold) scramble();
            @(negedge clk);
            checkCycle({tag, ".hi"}, 1, a + 1, int'(d >> 16), 1, 0, 0);
        end else begin
            hi17 = int'(d >> 15);
            if (a < 5) ovf = !(hi17 == 0 || hi17 == 32'h1FFFF);
            else       ovf = (d >> 16) != 0;
            checkCycle({tag, ".half"}, 1, a, int'(d & 32'hFFFF), 1, int'(ovf), 0);
        end
        if (hold) scramble();
    endtask

    initial begin
        int a;
        logic [31:0] d;
        reset       = 1'b1;
        store_valid = 1'b0;
        store_addr  = '0;
        store_data  = '0;
        #12;
        chk("rst.ready", 32'(store_ready), 32'd1);
        chk("rst.we", 32'(sram_we), 32'd0);
        chk("rst.addr", 32'(sram_addr), 32'd0);
        chk("rst.wdata", 32'(sram_wdata), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.ovf", 32'(overflow), 32'd0);
        chk("rst.err", 32'(error), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        doStore("sgn3", 3, 32'hFFFF8000, 1'b0);
        doStore("sgnOvf4", 4, 32'h00008000, 1'b0);
        doStore("uns5", 5, 32'h0001FFFF, 1'b0);
        doStore("uns8", 8, 32'h0000FFFF, 1'b0);
        doStore("word9", 9, 32'hDEADBEEF, 1'b0);
        doStore("fault2047", 2047, 32'h12345678, 1'b0);
        doStore("word2046", 2046, 32'hCAFEF00D, 1'b0);
        doStore("stallWord", 20, 32'hA5A55A5A, 1'b1);
        doStore("stallHalf", 6, 32'h00001234, 1'b1);
        doStore("stallFault", 2047, 32'h0, 1'b1);
        doStore("afterStall", 0, 32'hFFFFFFFF, 1'b0);
        store_valid = 1'b0;

        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 3))
                0:       a = int'($urandom_range(0, 12));
                1:       a = int'($urandom_range(2044, 2047));
                default: a = int'($urandom_range(0, 2047));
            endcase
            case ($urandom_range(0, 2))
                0:       d = 32'($signed(16'($urandom)));
                1:       d = 32'($urandom_range(0, 32'h1FFFF));
                default: d = $urandom;
            endcase
            doStore("rnd", a, d, 1'($urandom_range(0, 1)));
        end
        store_valid = 1'b0;

        // Reset in the middle of a word store: low half is in flight, high half
        // must never appear and no done is seen.
        @(negedge clk);
        store_valid = 1'b1;
        store_addr  = 11'd20;
        store_data  = 32'h11223344;
        @(posedge clk);
        #1;
        store_valid = 1'b0;
        @(negedge clk);
        chk("abort.loWe", 32'(sram_we), 32'd1);
        chk("abort.loAddr", 32'(sram_addr), 32'd20);
        #2;
        reset = 1'b1;
        #1;
        chk("abort.weAsync", 32'(sram_we), 32'd0);
        chk("abort.doneAsync", 32'(done), 32'd0);
        @(negedge clk);
        chk("abort.weHeld", 32'(sram_we), 32'd0);
        chk("abort.doneHeld", 32'(done), 32'd0);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post.ready", 32'(store_ready), 32'd1);
            chk("post.we", 32'(sram_we), 32'd0);
            chk("post.addr", 32'(sram_addr), 32'd0);
            chk("post.wdata", 32'(sram_wdata), 32'd0);
            chk("post.done", 32'(done), 32'd0);
            chk("post.ovf", 32'(overflow), 32'd0);
            chk("post.err", 32'(error), 32'd0);
        end
        doStore("postWord", 9, 32'h0BADCAFE, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
